// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : handshaked execute-stage ALU for the JOF32 pipeline.
//
// Single-cycle operations load the result registers at the accepting edge.
// MULT (shift-add) and DIV (restoring) run one iteration per cycle for WIDTH
// cycles in the EXEC state and then load the result.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous abort of any in-flight or held operation
//   in_valid   : operands/opcode valid
//   in_ready   : an operation is accepted this cycle (combinational)
//   a, b       : operands (b also supplies the shift amount b[SHW-1:0])
//   opcode     : 5-bit operation select
//   out_valid  : result registers hold a valid result
//   out_ready  : downstream consumes the result
//   resultado  : result
//   taken      : branch condition for BEQ/BNE, otherwise 0
//   zero       : resultado == 0
//   div0       : DIV with b == 0
//   illegal    : opcode outside the map
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic             taken,
    output logic             zero,
    output logic             div0,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_NOR  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_MULT = 5'b00111;
    localparam logic [4:0] OP_DIV  = 5'b01000;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_BNE  = 5'b01010;
    localparam logic [4:0] OP_LW   = 5'b01011;
    localparam logic [4:0] OP_LB   = 5'b01100;
    localparam logic [4:0] OP_SW   = 5'b01101;
    localparam logic [4:0] OP_J    = 5'b01110;
    localparam logic [4:0] OP_SRA  = 5'b10000;
    localparam logic [4:0] OP_SLT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Single-cycle datapath result for every non-iterative opcode.
    function automatic logic [WIDTH-1:0] f_alu(input logic [4:0]       op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] res;
        logic [SHW-1:0]   sh;
        sh = y[SHW-1:0];
        case (op)
            OP_ADD:              res = x + y;
            OP_SUB:              res = x - y;
            OP_AND:              res = x & y;
            OP_OR:               res = x | y;
            OP_NOR:              res = ~(x | y);
            OP_SLL:              res = x << sh;
            OP_SRL:              res = x >> sh;
            OP_SRA:              res = $unsigned($signed(x) >>> sh);
            OP_SLT:              res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_LW, OP_LB, OP_SW: res = x + y;
            default:             res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Opcode map membership.
    function automatic logic f_illegal(input logic [4:0] op);
        logic ill;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLL, OP_SRL,
            OP_MULT, OP_DIV, OP_BEQ, OP_BNE, OP_LW, OP_LB, OP_SW,
            OP_J, OP_SRA, OP_SLT, OP_NOP: ill = 1'b0;
            default:                      ill = 1'b1;
        endcase
        return ill;
    endfunction

    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic             r_is_div, w_is_div;
    // r_opa: multiplicand (MULT) or dividend/quotient shift register (DIV)
    // r_opb: multiplier (MULT) or divisor (DIV)
    // r_acc: product accumulator (MULT) or partial remainder (DIV)
    logic [WIDTH-1:0] r_opa, w_opa;
    logic [WIDTH-1:0] r_opb, w_opb;
    logic [WIDTH-1:0] r_acc, w_acc;
    logic [WIDTH-1:0] r_result, w_result;
    logic             r_taken, w_taken;
    logic             r_zero, w_zero;
    logic             r_div0, w_div0;
    logic             r_illegal, w_illegal;
    logic             r_out_valid, w_out_valid;

    logic             w_accept;
    logic             w_is_multi;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0] w_div_quo;

    assign in_ready   = rst_n && (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_is_multi = (opcode == OP_MULT) || (opcode == OP_DIV);
    assign w_single   = f_alu(opcode, a, b);

    // One shift-add step: add the multiplicand when the current multiplier LSB is set.
    assign w_mul_acc = r_opb[0] ? (r_acc + r_opa) : r_acc;

    // One restoring-division step: shift the next dividend bit into the remainder
    // and subtract the divisor; a non-negative difference yields quotient bit 1.
    // With a zero divisor the difference is never negative, so the quotient
    // naturally becomes all ones.
    assign w_rem_shift = {r_acc, r_opa[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_opb};

    // Restoring-division step result selection.
    always_comb begin
        if (!w_diff[WIDTH]) begin
            w_div_acc = w_diff[WIDTH-1:0];
            w_div_quo = {r_opa[WIDTH-2:0], 1'b1};
        end else begin
            w_div_acc = w_rem_shift[WIDTH-1:0];
            w_div_quo = {r_opa[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and next-output logic for the IDLE/EXEC controller.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_is_div    = r_is_div;
        w_opa       = r_opa;
        w_opb       = r_opb;
        w_acc       = r_acc;
        w_result    = r_result;
        w_taken     = r_taken;
        w_zero      = r_zero;
        w_div0      = r_div0;
        w_illegal   = r_illegal;
        w_out_valid = r_out_valid;

        if (flush) begin
            // Abort wins over any same-cycle accept or completion; result data is kept.
            w_state     = ST_IDLE;
            w_cnt       = {CW{1'b0}};
            w_out_valid = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_out_valid && out_ready) begin
                        w_out_valid = 1'b0;
                    end else begin
                        w_out_valid = r_out_valid;
                    end
                    if (w_accept) begin
                        if (w_is_multi) begin
                            w_state  = ST_EXEC;
                            w_cnt    = {CW{1'b0}};
                            w_is_div = (opcode == OP_DIV);
                            w_opa    = a;
                            w_opb    = b;
                            w_acc    = {WIDTH{1'b0}};
                        end else begin
                            w_result    = w_single;
                            w_taken     = ((opcode == OP_BEQ) && (a == b)) ||
                                          ((opcode == OP_BNE) && (a != b));
                            w_zero      = (w_single == {WIDTH{1'b0}});
                            w_div0      = 1'b0;
                            w_illegal   = f_illegal(opcode);
                            w_out_valid = 1'b1;
                        end
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    w_cnt = r_cnt + CW'(1);
                    if (r_is_div) begin
                        w_acc = w_div_acc;
                        w_opa = w_div_quo;
                    end else begin
                        w_acc = w_mul_acc;
                        w_opa = r_opa << 1;
                        w_opb = r_opb >> 1;
                    end
                    // The final iteration and the result load share one edge.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_state     = ST_IDLE;
                        w_cnt       = {CW{1'b0}};
                        w_result    = r_is_div ? w_div_quo : w_mul_acc;
                        w_taken     = 1'b0;
                        w_illegal   = 1'b0;
                        w_div0      = r_is_div && (r_opb == {WIDTH{1'b0}});
                        w_zero      = r_is_div ? (w_div_quo == {WIDTH{1'b0}})
                                               : (w_mul_acc == {WIDTH{1'b0}});
                        w_out_valid = 1'b1;
                    end else begin
                        w_state = ST_EXEC;
                    end
                end
                default: begin
                    w_state     = ST_IDLE;
                    w_cnt       = {CW{1'b0}};
                    w_out_valid = 1'b0;
                end
            endcase
        end
    end

    // State, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_is_div    <= 1'b0;
            r_opa       <= {WIDTH{1'b0}};
            r_opb       <= {WIDTH{1'b0}};
            r_acc       <= {WIDTH{1'b0}};
            r_result    <= {WIDTH{1'b0}};
            r_taken     <= 1'b0;
            r_zero      <= 1'b1;
            r_div0      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_is_div    <= w_is_div;
            r_opa       <= w_opa;
            r_opb       <= w_opb;
            r_acc       <= w_acc;
            r_result    <= w_result;
            r_taken     <= w_taken;
            r_zero      <= w_zero;
            r_div0      <= w_div0;
            r_illegal   <= w_illegal;
            r_out_valid <= w_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign resultado = r_result;
    assign taken     = r_taken;
    assign zero      = r_zero;
    assign div0      = r_div0;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// Scoreboard testbench for alu_seq: a driver pushes reference-model results
// into a queue at accept time, and a monitor compares each new DUT result
// (value, flags, latency) and checks that held results stay stable.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W   = 32;
    localparam int SHW = $clog2(W);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_NOR  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_MULT = 5'b00111;
    localparam logic [4:0] OP_DIV  = 5'b01000;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_BNE  = 5'b01010;
    localparam logic [4:0] OP_LW   = 5'b01011;
    localparam logic [4:0] OP_LB   = 5'b01100;
    localparam logic [4:0] OP_SW   = 5'b01101;
    localparam logic [4:0] OP_J    = 5'b01110;
    localparam logic [4:0] OP_SRA  = 5'b10000;
    localparam logic [4:0] OP_SLT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] resultado;
    logic         taken;
    logic         zero;
    logic         div0;
    logic         illegal;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .taken     (taken),
        .zero      (zero),
        .div0      (div0),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flags;   // {taken, zero, div0, illegal}
        int           lat;
        int           pres;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   or_mode = 1;         // 0: out_ready low, 1: high, 2: random
    bit   last_same;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural reference: what the opcode map says the result must be.
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t           e;
        logic [2*W-1:0] prod;
        logic           tk;
        logic           d0;
        logic           il;
        int             sh;
        sh   = int'(y[SHW-1:0]);
        tk   = 1'b0;
        d0   = 1'b0;
        il   = 1'b0;
        e.lat  = 1;
        e.pres = 0;
        case (op)
            OP_ADD, OP_LW, OP_LB, OP_SW: e.res = x + y;
            OP_SUB:  e.res = x - y;
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_NOR:  e.res = ~(x | y);
            OP_SLL:  e.res = x << sh;
            OP_SRL:  e.res = x >> sh;
            OP_SRA:  e.res = $unsigned($signed(x) >>> sh);
            OP_SLT:  e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            OP_BEQ: begin e.res = '0; tk = (x == y); end
            OP_BNE: begin e.res = '0; tk = (x != y); end
            OP_J, OP_NOP: e.res = '0;
            OP_MULT: begin
                prod  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.res = prod[W-1:0];
                e.lat = W + 1;
            end
            OP_DIV: begin
                if (y == '0) begin
                    e.res = '1;
                    d0    = 1'b1;
                end else begin
                    e.res = x / y;
                end
                e.lat = W + 1;
            end
            default: begin e.res = '0; il = 1'b1; end
        endcase
        e.flags = {tk, (e.res == '0), d0, il};
        return e;
    endfunction

    // out_ready settles just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Present one operation and wait (bounded) for the negedge before its accepting edge.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   guard;
        bit   done;
        guard = 0;
        done  = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        opcode   = op;
        a        = x;
        b        = y;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e      = model(op, x, y);
                e.pres = cyc;
                exp_q.push_back(e);
                last_same = out_valid && out_ready;
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 200) begin
                    chk("accept_timeout", 64'(in_ready), 64'(1));
                    done = 1'b1;
                end else begin
                    done = 1'b0;
                end
            end
        end
    endtask

    // Drop in_valid and scramble the operand bus so captured values are what count.
    task automatic idle();
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = 5'($urandom_range(0, 31));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: compares each newly presented result and checks hold stability.
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic         hold_pend  = 1'b0;
    logic [W+3:0] held;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
                hold_pend  = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 64'(out_valid), 64'(1));
                    chk("hold_data", 64'({resultado, taken, zero, div0, illegal}), 64'(held));
                end
                if (out_valid && (!prev_valid || prev_ready)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 64'(out_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", 64'(resultado), 64'(e.res));
                        chk("flags_tk_zr_d0_il", 64'({taken, zero, div0, illegal}), 64'(e.flags));
                        chk("latency", 64'(cyc - e.pres), 64'(e.lat));
                    end
                end
                hold_pend  = out_valid && !out_ready && !flush;
                held       = {resultado, taken, zero, div0, illegal};
                prev_valid = out_valid;
                prev_ready = out_ready;
            end
        end
    end

    initial begin
        int           bad;
        logic [4:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        opcode   = OP_NOP;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({out_valid, resultado, taken, zero, div0, illegal}),
            64'({1'b0, {W{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0}));
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed single-cycle operations, back to back
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        issue(OP_SUB, 32'h0, 32'h1);
        issue(OP_SRA, 32'h8000_0000, 32'h24);
        issue(OP_SRL, 32'h8000_0000, 32'h24);
        issue(OP_NOR, 32'h0, 32'h0);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
        issue(OP_SLL, 32'h0000_0001, 32'h1F);
        issue(5'b10110, 32'h1234_5678, 32'h9ABC_DEF0);
        idle();

        // MULT: in_ready must stay low for the whole iteration window
        issue(OP_MULT, 32'h0001_0001, 32'h0001_0001);
        idle();
        bad = 0;
        repeat (W) begin
            @(negedge clk);
            if (in_ready) bad++;
        end
        chk("mult_in_ready_low_cycles", 64'(bad), 64'(0));
        issue(OP_DIV, 32'd100, 32'd7);
        issue(OP_DIV, 32'd5, 32'd0);
        idle();
        drain();

        // Backpressure: BEQ held, then consume and accept ADD in the same cycle
        or_mode = 0;
        issue(OP_BEQ, 32'd3, 32'd3);
        idle();
        repeat (3) @(negedge clk);
        chk("bp_held", 64'({out_valid, taken, in_ready}), 64'({1'b1, 1'b1, 1'b0}));
        or_mode = 1;
        issue(OP_ADD, 32'd5, 32'd6);
        chk("bp_consume_and_accept", 64'(last_same), 64'(1));
        idle();
        drain();

        // Flush on cycle 10 of a DIV
        issue(OP_DIV, 32'd100, 32'd7);
        idle();
        repeat (9) @(posedge clk);
        #2;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_masks_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #2;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("after_flush", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of a MULT
        issue(OP_MULT, 32'hDEAD_BEEF, 32'h0000_0003);
        idle();
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop_reset_outputs", 64'({out_valid, resultado, taken, zero, div0, illegal, in_ready}),
            64'({1'b0, {W{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Randomized traffic with random backpressure
        or_mode = 2;
        repeat (300) begin
            op = 5'($urandom_range(0, 31));
            if ((op == OP_MULT || op == OP_DIV) && $urandom_range(0, 3) != 0)
                op = 5'($urandom_range(0, 6));
            x = W'($urandom);
            case ($urandom_range(0, 7))
                0:       y = '0;
                1:       y = x;
                2:       y = W'($urandom_range(1, 40));
                default: y = W'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) x = W'($urandom_range(0, 300));
            issue(op, x, y);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        or_mode = 1;
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
